morse_match_engine: RTL and testbench

Parametrised letter-matching game engine for the Morse decoder. It sits between the decoder's debounced letter-enter path and the score displays. It compares each decoded ASCII letter against the current target word, read from an external word ROM, and lights per-letter progress LEDs. It also tracks points, misses and a persistent high score under four game modes, generalising the fixed 5-letter, single-word matcher to configurable word length, word count and score width.

---
 rtl/morse_match_engine.sv | 136 +++++++++++++
 tb/tb_morse_match_engine.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_match_engine.sv
// Letter-matching game engine: compares decoded letters against a ROM word,
// drives per-letter LEDs and tracks points, misses and high score across four game modes.
module morse_match_engine #(
    parameter int WORD_LEN   = 5,
    parameter int NUM_WORDS  = 32,
    parameter int SCORE_W    = 4,
    parameter int MAX_MISSES = 3,
    localparam int WI_W      = $clog2(NUM_WORDS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                letter_valid,
    input  logic [7:0]          ascii_in,
    input  logic [1:0]          mode,
    input  logic                timeout,
    input  logic [WI_W-1:0]     word_sel,
    output logic [WI_W-1:0]     word_idx,
    output logic [3:0]          char_idx,
    input  logic [7:0]          rom_char,
    output logic [WORD_LEN-1:0] letter_leds,
    output logic                match,
    output logic                miss,
    output logic                word_done,
    output logic [SCORE_W-1:0]  points,
    output logic [SCORE_W-1:0]  high_score,
    output logic [3:0]          misses,
    output logic                game_over
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] PLAY = 2'd2;
    localparam logic [1:0] OVER = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          r_mode;
    logic [WI_W-1:0]     r_word_idx;
    logic [3:0]          r_char_idx;
    logic [WORD_LEN-1:0] r_leds;
    logic                r_match, r_miss, r_word_done;
    logic [SCORE_W-1:0]  r_points, r_high;
    logic [3:0]          r_misses;

    logic                w_eq, w_last, w_do_miss, w_miss_end;
    logic [3:0]          w_miss_nxt;
    logic [SCORE_W-1:0]  w_pts_nxt, w_hs_nxt;
    logic [WORD_LEN-1:0] w_onehot;

    function automatic logic [7:0] fold(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    endfunction

    always_comb begin
        w_eq       = fold(ascii_in) == fold(rom_char);
        w_last     = r_char_idx == 4'(WORD_LEN - 1);
        w_miss_nxt = (r_misses == 4'hF) ? 4'hF : r_misses + 4'd1;
        // Timeout in timed mode ends the game outright; elsewhere it is just another miss.
        w_do_miss  = timeout ? (r_mode != 2'd2) : (letter_valid && !w_eq);
        w_miss_end = (r_mode == 2'd3) ||
                     ((r_mode == 2'd1 || r_mode == 2'd2) && w_miss_nxt >= 4'(MAX_MISSES));
        w_pts_nxt  = (r_mode == 2'd0 || r_points == {SCORE_W{1'b1}}) ? r_points
                                                                      : r_points + 1'b1;
        w_hs_nxt   = (r_points > r_high) ? r_points : r_high;
        w_onehot   = WORD_LEN'(1) << r_char_idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_mode      <= '0;
            r_word_idx  <= '0;
            r_char_idx  <= '0;
            r_leds      <= '0;
            r_match     <= 1'b0;
            r_miss      <= 1'b0;
            r_word_done <= 1'b0;
            r_points    <= '0;
            r_high      <= '0;
            r_misses    <= '0;
        end else begin
            r_match     <= 1'b0;
            r_miss      <= 1'b0;
            r_word_done <= 1'b0;
            if (start) begin
                r_state  <= LOAD;
                r_mode   <= mode;
                r_points <= '0;
                r_misses <= '0;
                r_leds   <= '0;
            end else begin
                case (r_state)
                    LOAD: begin
                        r_word_idx <= word_sel;
                        r_char_idx <= '0;
                        r_leds     <= '0;
                        r_state    <= PLAY;
                    end
                    PLAY: begin
                        if (timeout && r_mode == 2'd2) begin
                            r_state <= OVER;
                            r_high  <= w_hs_nxt;
                        end else if (w_do_miss) begin
                            r_miss   <= 1'b1;
                            r_misses <= w_miss_nxt;
                            if (w_miss_end) begin
                                r_state <= OVER;
                                r_high  <= w_hs_nxt;
                            end
                        end else if (letter_valid) begin
                            r_match    <= 1'b1;
                            r_leds     <= r_leds | w_onehot;
                            r_char_idx <= r_char_idx + 4'd1;
                            if (w_last) begin
                                r_word_done <= 1'b1;
                                r_points    <= w_pts_nxt;
                                r_state     <= LOAD;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign word_idx    = r_word_idx;
    assign char_idx    = r_char_idx;
    assign letter_leds = r_leds;
    assign match       = r_match;
    assign miss        = r_miss;
    assign word_done   = r_word_done;
    assign points      = r_points;
    assign high_score  = r_high;
    assign misses      = r_misses;
    assign game_over   = r_state == OVER;
endmodule

// File: tb/tb_morse_match_engine.sv
// Scoreboard bench for morse_match_engine: 3-letter words, 4-word ROM, 2-bit score.
module tb_morse_match_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, letter_valid = 1'b0, timeout = 1'b0;
    logic [7:0] ascii_in = 8'h00;
    logic [1:0] mode = 2'd0;
    logic [1:0] word_sel = 2'd0;
    logic [1:0] word_idx;
    logic [3:0] char_idx;
    logic [7:0] rom_char;
    logic [2:0] letter_leds;
    logic       match, miss, word_done, game_over;
    logic [1:0] points, high_score;
    logic [3:0] misses;

    always #5 clk = ~clk;

    morse_match_engine #(.WORD_LEN(3), .NUM_WORDS(4), .SCORE_W(2), .MAX_MISSES(3)) dut (
        .clk(clk), .rst(rst), .start(start), .letter_valid(letter_valid),
        .ascii_in(ascii_in), .mode(mode), .timeout(timeout), .word_sel(word_sel),
        .word_idx(word_idx), .char_idx(char_idx), .rom_char(rom_char),
        .letter_leds(letter_leds), .match(match), .miss(miss), .word_done(word_done),
        .points(points), .high_score(high_score), .misses(misses), .game_over(game_over)
    );

    // ROM: "SOS", "CAT", "a1z" (lower case exercises folding), "DOG"
    logic [7:0] rom [4][3];
    initial begin
        rom[0][0] = "S"; rom[0][1] = "O"; rom[0][2] = "S";
        rom[1][0] = "C"; rom[1][1] = "A"; rom[1][2] = "T";
        rom[2][0] = "a"; rom[2][1] = "1"; rom[2][2] = "z";
        rom[3][0] = "D"; rom[3][1] = "O"; rom[3][2] = "G";
    end
    always_comb rom_char = (char_idx < 4'd3) ? rom[word_idx][char_idx[1:0]] : 8'h00;

    typedef struct packed {
        logic m, x, d; logic [2:0] leds; logic [1:0] pts; logic [3:0] ms; logic ov; logic [1:0] hs;
    } obs_t;
    typedef struct packed {
        logic st; logic [1:0] md; logic lv; logic [7:0] ch; logic to; logic [1:0] ws; obs_t e;
    } stim_t;

    obs_t  sb_q[$];
    stim_t tab[$];
    int    n_cmp = 0, n_mis = 0;
    logic [1:0] cur_ws = 2'd0;

    function automatic obs_t E(input logic m, x, d, input logic [2:0] l, input logic [1:0] p,
                               input logic [3:0] ms, input logic ov, input logic [1:0] hs);
        return {m, x, d, l, p, ms, ov, hs};
    endfunction
    function stim_t mk(input logic st, input logic [1:0] md, input logic lv,
                       input logic [7:0] ch, input logic to, input obs_t e);
        return {st, md, lv, ch, to, cur_ws, e};
    endfunction
    function obs_t snap();
        return {match, miss, word_done, letter_leds, points, misses, game_over, high_score};
    endfunction

    task automatic drive(input stim_t s);
        @(negedge clk);
        start = s.st; mode = s.md; letter_valid = s.lv; ascii_in = s.ch;
        timeout = s.to; word_sel = s.ws;
        @(posedge clk); #1;
        start = 1'b0; letter_valid = 1'b0; timeout = 1'b0;
    endtask

    task automatic test_reset;
        obs_t got;
        rst = 1'b0; start = 1'b1; letter_valid = 1'b1; timeout = 1'b1;
        repeat (3) @(posedge clk);
        #1; got = snap(); n_cmp++;
        if (got !== '0 || word_idx !== 2'd0 || char_idx !== 4'd0) begin
            n_mis++;
            $display("FAIL reset: got %h idx %0d/%0d expected 0", got, word_idx, char_idx);
        end
        start = 1'b0; letter_valid = 1'b0; timeout = 1'b0;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_match_sos;
        obs_t got, e;
        tab = {};
        cur_ws = 2'd0;
        tab.push_back(mk(1, 2'd1, 0, 0, 0, E(0,0,0,3'b000,0,0,0,0)));
        tab.push_back(mk(0, 2'd1, 0, 0, 0, E(0,0,0,3'b000,0,0,0,0)));
        tab.push_back(mk(0, 2'd1, 1, "S", 0, E(1,0,0,3'b001,0,0,0,0)));
        tab.push_back(mk(0, 2'd1, 1, "o", 0, E(1,0,0,3'b011,0,0,0,0)));
        cur_ws = 2'd1;
        tab.push_back(mk(0, 2'd1, 1, "S", 0, E(1,0,1,3'b111,1,0,0,0)));
        tab.push_back(mk(0, 2'd1, 1, "C", 0, E(0,0,0,3'b000,1,0,0,0))); // dropped in LOAD
        tab.push_back(mk(0, 2'd1, 1, "c", 0, E(1,0,0,3'b001,1,0,0,0)));
        for (int i = 0; i < tab.size(); i++) begin
            sb_q.push_back(tab[i].e);
            drive(tab[i]);
            got = snap(); e = sb_q.pop_front(); n_cmp++;
            if (got !== e) begin n_mis++; $display("FAIL match_sos step %0d: got %h expected %h", i, got, e); end
        end
    endtask

    task automatic test_miss_over;
        obs_t got, e;
        tab = {};
        tab.push_back(mk(0, 2'd1, 1, "X", 0, E(0,1,0,3'b001,1,1,0,0)));
        tab.push_back(mk(0, 2'd1, 1, "X", 0, E(0,1,0,3'b001,1,2,0,0)));
        tab.push_back(mk(0, 2'd1, 1, "X", 0, E(0,1,0,3'b001,1,3,1,1)));
        tab.push_back(mk(0, 2'd1, 1, "A", 0, E(0,0,0,3'b001,1,3,1,1)));
        tab.push_back(mk(0, 2'd1, 0, 0, 1, E(0,0,0,3'b001,1,3,1,1)));
        for (int i = 0; i < tab.size(); i++) begin
            sb_q.push_back(tab[i].e);
            drive(tab[i]);
            got = snap(); e = sb_q.pop_front(); n_cmp++;
            if (got !== e) begin n_mis++; $display("FAIL miss_over step %0d: got %h expected %h", i, got, e); end
        end
    endtask

    task automatic test_timed;
        obs_t got, e;
        tab = {};
        cur_ws = 2'd2;
        tab.push_back(mk(1, 2'd2, 0, 0, 0, E(0,0,0,3'b000,0,0,0,1)));
        tab.push_back(mk(0, 2'd2, 0, 0, 0, E(0,0,0,3'b000,0,0,0,1)));
        tab.push_back(mk(0, 2'd2, 1, "A", 0, E(1,0,0,3'b001,0,0,0,1)));
        tab.push_back(mk(0, 2'd2, 1, "X", 0, E(0,1,0,3'b001,0,1,0,1)));
        tab.push_back(mk(0, 2'd2, 1, "1", 1, E(0,0,0,3'b001,0,1,1,1)));
        for (int i = 0; i < tab.size(); i++) begin
            sb_q.push_back(tab[i].e);
            drive(tab[i]);
            got = snap(); e = sb_q.pop_front(); n_cmp++;
            if (got !== e) begin n_mis++; $display("FAIL timed step %0d: got %h expected %h", i, got, e); end
        end
    endtask

    task automatic test_strict;
        obs_t got, e;
        tab = {};
        cur_ws = 2'd3;
        tab.push_back(mk(1, 2'd3, 0, 0, 0, E(0,0,0,3'b000,0,0,0,1)));
        tab.push_back(mk(0, 2'd3, 0, 0, 0, E(0,0,0,3'b000,0,0,0,1)));
        tab.push_back(mk(0, 2'd3, 1, "d", 0, E(1,0,0,3'b001,0,0,0,1)));
        tab.push_back(mk(0, 2'd3, 1, "Q", 0, E(0,1,0,3'b001,0,1,1,1)));
        for (int i = 0; i < tab.size(); i++) begin
            sb_q.push_back(tab[i].e);
            drive(tab[i]);
            got = snap(); e = sb_q.pop_front(); n_cmp++;
            if (got !== e) begin n_mis++; $display("FAIL strict step %0d: got %h expected %h", i, got, e); end
        end
    endtask

    task automatic test_practice;
        obs_t got, e;
        tab = {};
        cur_ws = 2'd0;
        tab.push_back(mk(1, 2'd0, 0, 0, 0, E(0,0,0,3'b000,0,0,0,1)));
        tab.push_back(mk(0, 2'd0, 0, 0, 0, E(0,0,0,3'b000,0,0,0,1)));
        tab.push_back(mk(0, 2'd0, 1, "S", 0, E(1,0,0,3'b001,0,0,0,1)));
        tab.push_back(mk(0, 2'd0, 1, "O", 0, E(1,0,0,3'b011,0,0,0,1)));
        tab.push_back(mk(0, 2'd0, 1, "S", 0, E(1,0,1,3'b111,0,0,0,1)));
        tab.push_back(mk(0, 2'd0, 0, 0, 0, E(0,0,0,3'b000,0,0,0,1)));
        for (int k = 1; k <= 20; k++)
            tab.push_back(mk(0, 2'd0, k[0] == 1'b0, "Z", k[0],
                             E(0,1,0,3'b000,0,(k > 15) ? 4'd15 : 4'(k),0,1)));
        for (int i = 0; i < tab.size(); i++) begin
            sb_q.push_back(tab[i].e);
            drive(tab[i]);
            got = snap(); e = sb_q.pop_front(); n_cmp++;
            if (got !== e) begin n_mis++; $display("FAIL practice step %0d: got %h expected %h", i, got, e); end
        end
    endtask

    task automatic test_saturate;
        obs_t got, e;
        logic [1:0] p, pn;
        tab = {};
        cur_ws = 2'd0;
        tab.push_back(mk(1, 2'd1, 0, 0, 0, E(0,0,0,3'b000,0,0,0,1)));
        tab.push_back(mk(0, 2'd1, 0, 0, 0, E(0,0,0,3'b000,0,0,0,1)));
        for (int w = 0; w < 5; w++) begin
            p  = (w > 3) ? 2'd3 : 2'(w);
            pn = (w + 1 > 3) ? 2'd3 : 2'(w + 1);
            tab.push_back(mk(0, 2'd1, 1, "S", 0, E(1,0,0,3'b001,p,0,0,1)));
            tab.push_back(mk(0, 2'd1, 1, "O", 0, E(1,0,0,3'b011,p,0,0,1)));
            tab.push_back(mk(0, 2'd1, 1, "S", 0, E(1,0,1,3'b111,pn,0,0,1)));
            tab.push_back(mk(0, 2'd1, 0, 0, 0, E(0,0,0,3'b000,pn,0,0,1)));
        end
        tab.push_back(mk(0, 2'd1, 1, "X", 0, E(0,1,0,3'b000,3,1,0,1)));
        tab.push_back(mk(0, 2'd1, 0, 0, 1, E(0,1,0,3'b000,3,2,0,1)));
        tab.push_back(mk(0, 2'd1, 1, "X", 0, E(0,1,0,3'b000,3,3,1,3)));
        for (int i = 0; i < tab.size(); i++) begin
            sb_q.push_back(tab[i].e);
            drive(tab[i]);
            got = snap(); e = sb_q.pop_front(); n_cmp++;
            if (got !== e) begin n_mis++; $display("FAIL saturate step %0d: got %h expected %h", i, got, e); end
        end
    endtask

    task automatic test_restart;
        obs_t got, e;
        tab = {};
        cur_ws = 2'd0;
        tab.push_back(mk(1, 2'd1, 0, 0, 0, E(0,0,0,3'b000,0,0,0,3)));
        tab.push_back(mk(0, 2'd1, 0, 0, 0, E(0,0,0,3'b000,0,0,0,3)));
        tab.push_back(mk(0, 2'd1, 1, "S", 0, E(1,0,0,3'b001,0,0,0,3)));
        tab.push_back(mk(1, 2'd1, 1, "O", 1, E(0,0,0,3'b000,0,0,0,3))); // start beats letter/timeout
        tab.push_back(mk(0, 2'd1, 0, 0, 0, E(0,0,0,3'b000,0,0,0,3)));
        tab.push_back(mk(0, 2'd1, 1, "S", 0, E(1,0,0,3'b001,0,0,0,3)));
        for (int i = 0; i < tab.size(); i++) begin
            sb_q.push_back(tab[i].e);
            drive(tab[i]);
            got = snap(); e = sb_q.pop_front(); n_cmp++;
            if (got !== e) begin n_mis++; $display("FAIL restart step %0d: got %h expected %h", i, got, e); end
        end
    endtask

    task automatic test_rst_mid;
        obs_t got;
        @(negedge clk); #2;
        rst = 1'b0;
        #1; got = snap(); n_cmp++;
        if (got !== '0 || word_idx !== 2'd0 || char_idx !== 4'd0 || game_over !== 1'b0) begin
            n_mis++;
            $display("FAIL rst_mid: got %h idx %0d/%0d expected 0", got, word_idx, char_idx);
        end
        @(negedge clk); rst = 1'b1;
    endtask

    initial begin
        test_reset;
        test_match_sos;
        test_miss_over;
        test_timed;
        test_strict;
        test_practice;
        test_saturate;
        test_restart;
        test_rst_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
